// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier for the execute stage (MUL / SMULH / UMULH).
// One multiplier bit is consumed per clock. Signed operands are reduced to
// magnitudes on acceptance, and the sign is reapplied to the full 2N-bit product.
module iter_multiplier #(
    parameter int REGISTER_LENGTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       signed_i,
    input  logic [REGISTER_LENGTH-1:0] a_i,
    input  logic [REGISTER_LENGTH-1:0] b_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [REGISTER_LENGTH-1:0] result_o,
    output logic [REGISTER_LENGTH-1:0] result_hi_o
);

    localparam int N  = REGISTER_LENGTH;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // The magnitude of the most-negative value is 2^(N-1), which still fits
    // in N unsigned bits, so negating in place is exact.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic is_signed);
        logic signed [N-1:0] sx;
        sx = x;
        if (is_signed && x[N-1])
            return N'(-sx);
        return x;
    endfunction

    // Applies the product sign as a two's-complement negation over 2N bits.
    function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] p, input logic neg);
        logic signed [2*N-1:0] sp;
        sp = p;
        if (neg)
            return (2*N)'(-sp);
        return p;
    endfunction

    logic          sign_a_q, sign_b_q;
    logic [N-1:0]  mcand_q, mplier_q;
    logic [2*N-1:0] acc_q;
    logic [CW-1:0] cnt_q;

    logic [N:0]     add_sum;
    logic [2*N-1:0] acc_next;

    // One shift-add step: conditional add into the upper half with carry kept,
    // then the whole accumulator shifts right by one.
    always_comb begin
        add_sum  = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
        acc_next = {add_sum, acc_q[N-1:1]};
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; DONE always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = BUSY;
            BUSY:    if (cnt_q == LAST_ITER) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration and result loading.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_o    <= '0;
            result_hi_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sign_a_q <= signed_i & a_i[N-1];
                        sign_b_q <= signed_i & b_i[N-1];
                        mcand_q  <= magnitude(a_i, signed_i);
                        mplier_q <= magnitude(b_i, signed_i);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_next;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER)
                        {result_hi_o, result_o} <= apply_sign(acc_next, sign_a_q ^ sign_b_q);
                end
                default: ;
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);

endmodule
